// File: rtl/i2c_log_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_log_arbiter
//  Purpose  : Round-robin scheduler sharing the debug I2C frame logger between
//             N_REQ (page,value) producers. Holds one pending sample per
//             requester, issues one logger transaction at a time and enforces
//             a fixed idle gap after each transaction.
//  Options  : LOG_ARB_WDOG_EN - enables the busy-high watchdog in WAIT_LO and
//             the wdog_cnt abort counter (tied to 0 otherwise).
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_log_arbiter #(
  parameter int N_REQ         = 4,
  parameter int GAP_CYC       = 64,
  parameter int BUSY_RISE_MAX = 8,
  parameter int WDOG_CYC      = 2700000
) (
  input  logic                 cam1_pclk,
  input  logic                 cam_resetn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_page,
  input  logic [16*N_REQ-1:0]  req_value,
  output logic [N_REQ-1:0]     pend,
  input  logic                 log_busy,
  output logic                 log_new,
  output logic [7:0]           log_page,
  output logic [15:0]          log_value,
  output logic [2:0]           grant_id,
  output logic [15:0]          drop_cnt,
  output logic [7:0]           wdog_cnt
);

  // Elaboration-time sanity check of the configuration.
  if (N_REQ < 2 || N_REQ > 8 || GAP_CYC < 1 || BUSY_RISE_MAX < 1 || WDOG_CYC < 1) begin : g_param_check
    $error("i2c_log_arbiter: illegal parameter combination");
  end

  // One counter serves both the busy-rise timeout and the idle gap.
  localparam int CNT_MAX = (GAP_CYC > BUSY_RISE_MAX) ? GAP_CYC : BUSY_RISE_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [7:0]      slot_page_q  [N_REQ];
  logic [7:0]      slot_page_d  [N_REQ];
  logic [15:0]     slot_value_q [N_REQ];
  logic [15:0]     slot_value_d [N_REQ];
  logic            log_new_q, log_new_d;
  logic [7:0]      log_page_q, log_page_d;
  logic [15:0]     log_value_q, log_value_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic            do_grant;
  logic            hi_found;
  logic [2:0]      hi_idx;
  logic [2:0]      any_idx;
  logic [2:0]      gnt_sel;
  logic [N_REQ-1:0] gnt_vec;
  logic [3:0]      n_drop;
  logic [16:0]     drop_sum;

`ifdef LOG_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0]   wd_q, wd_d;
  logic [7:0]      wdog_cnt_q, wdog_cnt_d;
`endif

  // Round-robin pick: lowest pending index at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 3'd0;
    any_idx  = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        any_idx = 3'(i);
        if (3'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
        end
      end
    end
    gnt_sel  = hi_found ? hi_idx : any_idx;
    do_grant = (state_q == S_IDLE) && (|pend_q) && !log_busy;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_vec[i] = do_grant && (gnt_sel == 3'(i));
    end
  end

  // Slot capture, pending flags and saturating overwrite counter.
  always_comb begin
    pend_d = pend_q;
    n_drop = 4'd0;
    for (int i = 0; i < N_REQ; i++) begin
      slot_page_d[i]  = slot_page_q[i];
      slot_value_d[i] = slot_value_q[i];
      if (req_valid[i]) begin
        slot_page_d[i]  = req_page[8*i +: 8];
        slot_value_d[i] = req_value[16*i +: 16];
        pend_d[i]       = 1'b1;
        // A sample being granted this cycle leaves the slot, so it is not lost.
        if (pend_q[i] && !gnt_vec[i]) begin
          n_drop = n_drop + 4'd1;
        end
      end else if (gnt_vec[i]) begin
        pend_d[i] = 1'b0;
      end
    end
    drop_sum   = {1'b0, drop_cnt_q} + {13'd0, n_drop};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Transaction sequencing: grant, issue strobe, busy handshake, idle gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    log_new_d   = 1'b0;
    log_page_d  = log_page_q;
    log_value_d = log_value_q;
    grant_id_d  = grant_id_q;
`ifdef LOG_ARB_WDOG_EN
    wd_d        = wd_q;
    wdog_cnt_d  = wdog_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (do_grant) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt_sel == 3'(i)) begin
              log_page_d  = slot_page_q[i];
              log_value_d = slot_value_q[i];
            end
          end
          grant_id_d = gnt_sel;
          rr_ptr_d   = (gnt_sel == 3'(N_REQ - 1)) ? 3'd0 : gnt_sel + 3'd1;
          log_new_d  = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (log_busy) begin
          cnt_d   = '0;
`ifdef LOG_ARB_WDOG_EN
          wd_d    = '0;
`endif
          state_d = S_WAIT_LO;
        end else if (cnt_q == CW'(BUSY_RISE_MAX - 1)) begin
          // Logger never acknowledged; treat the transaction as finished.
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!log_busy) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
`ifdef LOG_ARB_WDOG_EN
        else if (wd_q == WW'(WDOG_CYC - 1)) begin
          // Logger hung: abandon the sample and keep serving the others.
          cnt_d      = '0;
          state_d    = S_GAP;
          wdog_cnt_d = (wdog_cnt_q == 8'hFF) ? 8'hFF : wdog_cnt_q + 8'd1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state flops; reset abandons any in-flight transaction immediately.
  always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
    if (!cam_resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= 3'd0;
      pend_q      <= '0;
      log_new_q   <= 1'b0;
      log_page_q  <= 8'd0;
      log_value_q <= 16'd0;
      grant_id_q  <= 3'd0;
      drop_cnt_q  <= 16'd0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_page_q[i]  <= 8'd0;
        slot_value_q[i] <= 16'd0;
      end
`ifdef LOG_ARB_WDOG_EN
      wd_q        <= '0;
      wdog_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      pend_q      <= pend_d;
      log_new_q   <= log_new_d;
      log_page_q  <= log_page_d;
      log_value_q <= log_value_d;
      grant_id_q  <= grant_id_d;
      drop_cnt_q  <= drop_cnt_d;
      for (int i = 0; i < N_REQ; i++) begin
        slot_page_q[i]  <= slot_page_d[i];
        slot_value_q[i] <= slot_value_d[i];
      end
`ifdef LOG_ARB_WDOG_EN
      wd_q        <= wd_d;
      wdog_cnt_q  <= wdog_cnt_d;
`endif
    end
  end

  assign pend      = pend_q;
  assign log_new   = log_new_q;
  assign log_page  = log_page_q;
  assign log_value = log_value_q;
  assign grant_id  = grant_id_q;
  assign drop_cnt  = drop_cnt_q;
`ifdef LOG_ARB_WDOG_EN
  assign wdog_cnt  = wdog_cnt_q;
`else
  assign wdog_cnt  = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_log_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_log_arbiter
//  Purpose  : Directed self-checking bench for i2c_log_arbiter with a simple
//             logger busy responder and an issue-event monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_log_arbiter;

  localparam int N_REQ         = 4;
  localparam int GAP_CYC       = 8;
  localparam int BUSY_RISE_MAX = 4;
  localparam int WDOG_CYC      = 100;
  localparam int BUSY_LEN      = 10;

  logic                cam1_pclk = 1'b0;
  logic                cam_resetn;
  logic [N_REQ-1:0]    req_valid;
  logic [8*N_REQ-1:0]  req_page;
  logic [16*N_REQ-1:0] req_value;
  logic [N_REQ-1:0]    pend;
  logic                log_busy;
  logic                log_new;
  logic [7:0]          log_page;
  logic [15:0]         log_value;
  logic [2:0]          grant_id;
  logic [15:0]         drop_cnt;
  logic [7:0]          wdog_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int busy_len = BUSY_LEN;
  int busy_left = 0;
  bit busy_stuck = 1'b0;

  int ev_cyc  [$];
  int ev_gid  [$];
  int ev_page [$];
  int ev_val  [$];

  i2c_log_arbiter #(
    .N_REQ(N_REQ), .GAP_CYC(GAP_CYC), .BUSY_RISE_MAX(BUSY_RISE_MAX), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .cam1_pclk (cam1_pclk),
    .cam_resetn(cam_resetn),
    .req_valid (req_valid),
    .req_page  (req_page),
    .req_value (req_value),
    .pend      (pend),
    .log_busy  (log_busy),
    .log_new   (log_new),
    .log_page  (log_page),
    .log_value (log_value),
    .grant_id  (grant_id),
    .drop_cnt  (drop_cnt),
    .wdog_cnt  (wdog_cnt)
  );

  always #5 cam1_pclk = ~cam1_pclk;

  always @(posedge cam1_pclk) cyc <= cyc + 1;

  // Logger model: busy rises one cycle after the issue strobe and holds busy_len cycles.
  always @(negedge cam1_pclk) begin
    if (busy_left > 0) begin
      log_busy  = 1'b1;
      busy_left = busy_left - 1;
    end else begin
      log_busy = 1'b0;
    end
    if (log_new) busy_left = busy_stuck ? 1000000 : busy_len;
  end

  // Issue-event recorder.
  always @(negedge cam1_pclk) begin
    if (log_new) begin
      ev_cyc.push_back(cyc);
      ev_gid.push_back(int'(grant_id));
      ev_page.push_back(int'(log_page));
      ev_val.push_back(int'(log_value));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cam1_pclk);
    #1;
  endtask

  task automatic wait_ev(input int n, input int budget);
    int t;
    t = 0;
    while (ev_cyc.size() < n && t < budget) begin
      tick();
      t++;
    end
    if (ev_cyc.size() < n) check("event_timeout", 32'(ev_cyc.size()), 32'(n));
  endtask

  task automatic set_req(input int i, input logic [7:0] pg, input logic [15:0] val);
    req_valid[i]          = 1'b1;
    req_page[8*i +: 8]    = pg;
    req_value[16*i +: 16] = val;
  endtask

  function automatic int evi(input int q [$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  int k;
  int b;
  int c;

  initial begin
    cam_resetn = 1'b0;
    req_valid  = '0;
    req_page   = '0;
    req_value  = '0;
    log_busy   = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_new", 32'(log_new), 32'h0);
    check("rst_page", 32'(log_page), 32'h0);
    check("rst_value", 32'(log_value), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_wdog", 32'(wdog_cnt), 32'h0);
    cam_resetn = 1'b1;
    repeat (2) tick();

    // 1: single request on req 2, latency and gap
    b = ev_cyc.size();
    set_req(2, 8'h05, 16'h1234);
    tick();
    k = cyc;
    req_valid = '0;
    check("t1_pend_set", 32'(pend), 32'h4);
    wait_ev(b + 1, 10);
    check("t1_latency", 32'(evi(ev_cyc, b)), 32'(k + 1));
    check("t1_page", 32'(evi(ev_page, b)), 32'h05);
    check("t1_value", 32'(evi(ev_val, b)), 32'h1234);
    check("t1_gid", 32'(evi(ev_gid, b)), 32'd2);
    check("t1_pend_clr", 32'(pend), 32'h0);
    check("t1_new_pulse", 32'(log_new), 32'h0);
    set_req(3, 8'h06, 16'h5678);
    tick();
    req_valid = '0;
    check("t1_page_stable", 32'(log_page), 32'h05);
    wait_ev(b + 2, 60);
    check("t1_spacing", 32'(evi(ev_cyc, b + 1) - evi(ev_cyc, b)), 32'(3 + BUSY_LEN + GAP_CYC));
    check("t1_gid2", 32'(evi(ev_gid, b + 1)), 32'd3);
    repeat (30) tick();

    // 2: all four strobe together, strict cyclic order
    b = ev_cyc.size();
    for (int i = 0; i < N_REQ; i++) set_req(i, 8'(8'h10 + i), 16'(16'hA000 + i));
    tick();
    req_valid = '0;
    wait_ev(b + 4, 150);
    for (int i = 0; i < N_REQ; i++) begin
      check("t2_order", 32'(evi(ev_gid, b + i)), 32'(i));
      check("t2_value", 32'(evi(ev_val, b + i)), 32'(16'hA000 + i));
    end
    check("t2_spacing", 32'(evi(ev_cyc, b + 3) - evi(ev_cyc, b + 2)), 32'(3 + BUSY_LEN + GAP_CYC));
    repeat (30) tick();
    b = ev_cyc.size();
    set_req(1, 8'h21, 16'h0021);
    set_req(0, 8'h20, 16'h0020);
    tick();
    req_valid = '0;
    wait_ev(b + 2, 80);
    check("t2_burst_first", 32'(evi(ev_gid, b)), 32'd0);
    check("t2_burst_second", 32'(evi(ev_gid, b + 1)), 32'd1);
    check("t2_drop", 32'(drop_cnt), 32'h0);
    repeat (30) tick();

    // 3: req 1 strobes three times while req 0 is in flight
    b = ev_cyc.size();
    set_req(0, 8'h30, 16'h0BEE);
    tick();
    req_valid = '0;
    wait_ev(b + 1, 10);
    set_req(1, 8'h31, 16'h1111); tick();
    set_req(1, 8'h32, 16'h2222); tick();
    set_req(1, 8'h33, 16'h3333); tick();
    req_valid = '0;
    wait_ev(b + 2, 60);
    check("t3_gid", 32'(evi(ev_gid, b + 1)), 32'd1);
    check("t3_value", 32'(evi(ev_val, b + 1)), 32'h3333);
    check("t3_page", 32'(evi(ev_page, b + 1)), 32'h33);
    check("t3_drop", 32'(drop_cnt), 32'd2);
    repeat (30) tick();

    // 4: granted slot re-strobes in the grant cycle
    b = ev_cyc.size();
    set_req(2, 8'h44, 16'h4444);
    tick();
    k = cyc;
    set_req(2, 8'h55, 16'h5555);
    tick();
    req_valid = '0;
    check("t4_pend_kept", 32'(pend), 32'h4);
    check("t4_drop_same", 32'(drop_cnt), 32'd2);
    wait_ev(b + 2, 60);
    check("t4_first_cyc", 32'(evi(ev_cyc, b)), 32'(k + 1));
    check("t4_old_value", 32'(evi(ev_val, b)), 32'h4444);
    check("t4_new_value", 32'(evi(ev_val, b + 1)), 32'h5555);
    check("t4_new_gid", 32'(evi(ev_gid, b + 1)), 32'd2);
    check("t4_drop_end", 32'(drop_cnt), 32'd2);
    repeat (30) tick();

    // 5: busy never rises
    busy_len = 0;
    b = ev_cyc.size();
    set_req(3, 8'h73, 16'h7373);
    set_req(0, 8'h70, 16'h7070);
    tick();
    req_valid = '0;
    wait_ev(b + 2, 40);
    check("t5_first_gid", 32'(evi(ev_gid, b)), 32'd3);
    check("t5_second_gid", 32'(evi(ev_gid, b + 1)), 32'd0);
    check("t5_spacing", 32'(evi(ev_cyc, b + 1) - evi(ev_cyc, b)), 32'(2 + BUSY_RISE_MAX + GAP_CYC));
    busy_len = BUSY_LEN;
    repeat (30) tick();

`ifdef LOG_ARB_WDOG_EN
    // 6a: watchdog abort with busy stuck high
    busy_stuck = 1'b1;
    b = ev_cyc.size();
    set_req(1, 8'h61, 16'h6161);
    tick();
    req_valid = '0;
    wait_ev(b + 1, 10);
    c = evi(ev_cyc, b);
    while (cyc < c + 101) tick();
    check("t6_wdog_before", 32'(wdog_cnt), 32'd0);
    tick();
    check("t6_wdog_abort", 32'(wdog_cnt), 32'd1);
    busy_stuck = 1'b0;
    busy_left  = 0;
    repeat (20) tick();
`else
    check("t6_wdog_tied", 32'(wdog_cnt), 32'd0);
`endif

    // 6b: asynchronous reset during a stuck WAIT_LO
    busy_stuck = 1'b1;
    b = ev_cyc.size();
    set_req(2, 8'h62, 16'h6262);
    tick();
    req_valid = '0;
    wait_ev(b + 1, 10);
    repeat (50) tick();
    check("t6_inflight_value", 32'(log_value), 32'h6262);
    check("t6_inflight_busy", 32'(log_busy), 32'd1);
    #2;
    cam_resetn = 1'b0;
    #1;
    check("t6_rst_pend", 32'(pend), 32'h0);
    check("t6_rst_new", 32'(log_new), 32'h0);
    check("t6_rst_page", 32'(log_page), 32'h0);
    check("t6_rst_value", 32'(log_value), 32'h0);
    check("t6_rst_gid", 32'(grant_id), 32'h0);
    check("t6_rst_drop", 32'(drop_cnt), 32'h0);
    check("t6_rst_wdog", 32'(wdog_cnt), 32'h0);
    busy_stuck = 1'b0;
    busy_left  = 0;
    repeat (3) tick();
    cam_resetn = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
